// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: latches per-source requests as pending, masks them with
// ENABLE, and presents the lowest-index winner to the CPU as a vector with a level ack handshake.
module irq_ctrl #(
  parameter int unsigned         NUM_SRC    = 4,
  parameter int unsigned         VEC_W      = 4,
  parameter logic [NUM_SRC-1:0]  EDGE_MODE  = '1,
  parameter logic [NUM_SRC-1:0]  ENABLE_RST = '1,
  parameter logic [63:0]         BASE_ADDR  = 64'h0000_0000_0000_FFE0
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic               bus_hit
);

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StAckWait
  } state_e;

  localparam logic [1:0] OffPending = 2'd0;
  localparam logic [1:0] OffEnable  = 2'd1;
  localparam logic [1:0] OffActive  = 2'd2;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   win_q, win_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [63:0]        rdata_q, rdata_d;

  logic [1:0]         offset;
  logic               wr_pending, wr_enable, rd_fire;
  logic [NUM_SRC-1:0] set_vec, w1c, ack_clr, req, win_onehot;
  logic [VEC_W-1:0]   win_idx;
  logic               any_req;
  logic [63:0]        rd_mux;
  logic               unused_bits;

  assign bus_hit    = (bus_address[63:5] == BASE_ADDR[63:5]);
  assign offset     = bus_address[4:3];
  assign wr_pending = bus_write_enable & bus_hit & (offset == OffPending);
  assign wr_enable  = bus_write_enable & bus_hit & (offset == OffEnable);
  assign rd_fire    = bus_read_enable & bus_hit;
  assign unused_bits = ^{bus_address[2:0], bus_write_data[63:NUM_SRC]};

  // Edge sources fire on a 0->1 transition, level sources every cycle they are high.
  assign set_vec = (EDGE_MODE & irq_src & ~src_prev_q) | (~EDGE_MODE & irq_src);
  assign w1c     = wr_pending ? bus_write_data[NUM_SRC-1:0] : '0;
  assign req     = pending_q & enable_q;

  // Fixed priority: scanning downwards leaves the lowest set index as the winner.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = VEC_W'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      win_onehot[i] = (win_q == VEC_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    win_d   = win_q;
    ack_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d   = win_idx;
          vec_d   = win_idx + VEC_W'(1);
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (interrupt_ack) begin
          ack_clr = win_onehot;
          vec_d   = '0;
          state_d = StAckWait;
        end else if (|(w1c & ~set_vec & win_onehot)) begin
          // Software withdrew the presented request before the CPU claimed it.
          vec_d   = '0;
          state_d = StIdle;
        end
      end
      StAckWait: begin
        vec_d = '0;
        if (!interrupt_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        vec_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Set wins over any clear landing on the same bit in the same cycle.
  assign pending_d = (pending_q & ~(w1c | ack_clr)) | set_vec;
  assign enable_d  = wr_enable ? bus_write_data[NUM_SRC-1:0] : enable_q;

  always_comb begin
    rd_mux = '0;
    unique case (offset)
      OffPending: rd_mux = {{(64-NUM_SRC){1'b0}}, pending_q};
      OffEnable:  rd_mux = {{(64-NUM_SRC){1'b0}}, enable_q};
      OffActive:  rd_mux = {{(64-VEC_W){1'b0}}, vec_q};
      default:    rd_mux = '0;
    endcase
  end

  assign rdata_d = rd_fire ? rd_mux : rdata_q;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      win_q      <= '0;
      pending_q  <= '0;
      enable_q   <= ENABLE_RST;
      src_prev_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      win_q      <= win_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      src_prev_q <= irq_src;
      rdata_q    <= rdata_d;
    end
  end

  assign interrupt_vector = vec_q;
  assign bus_read_data    = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: inputs change on the falling edge, outputs are checked on the
// falling edge, so every check sits half a cycle away from the active edge.
module tb_irq_ctrl;

  localparam logic [63:0] A_PEND = 64'h0000_0000_0000_FFE0;
  localparam logic [63:0] A_EN   = 64'h0000_0000_0000_FFE8;
  localparam logic [63:0] A_ACT  = 64'h0000_0000_0000_FFF0;
  localparam logic [63:0] A_RSV  = 64'h0000_0000_0000_FFF8;

  logic        CLOCK_50 = 1'b0;
  logic        KEY0 = 1'b0;
  logic [3:0]  irq_src = '0;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack = 1'b0;
  logic [63:0] bus_address = '0;
  logic [63:0] bus_write_data = '0;
  logic        bus_write_enable = 1'b0;
  logic        bus_read_enable = 1'b0;
  logic [63:0] bus_read_data;
  logic        bus_hit;

  int total = 0;
  int bad = 0;
  logic [63:0] rd;

  irq_ctrl #(
    .NUM_SRC   (4),
    .VEC_W     (4),
    .EDGE_MODE (4'b1110),
    .ENABLE_RST(4'b1111),
    .BASE_ADDR (64'h0000_0000_0000_FFE0)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .KEY0            (KEY0),
    .irq_src         (irq_src),
    .interrupt_vector(interrupt_vector),
    .interrupt_ack   (interrupt_ack),
    .bus_address     (bus_address),
    .bus_write_data  (bus_write_data),
    .bus_write_enable(bus_write_enable),
    .bus_read_enable (bus_read_enable),
    .bus_read_data   (bus_read_data),
    .bus_hit         (bus_hit)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLOCK_50);
  endtask

  task automatic bus_wr(input logic [63:0] addr, input logic [63:0] data);
    bus_address      = addr;
    bus_write_data   = data;
    bus_write_enable = 1'b1;
    cyc(1);
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] addr, output logic [63:0] data);
    bus_address     = addr;
    bus_read_enable = 1'b1;
    cyc(1);
    bus_read_enable = 1'b0;
    data = bus_read_data;
  endtask

  task automatic ack_pulse();
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
  endtask

  initial begin
    // Reset defaults with all requests asserted
    KEY0    = 1'b0;
    irq_src = 4'b1111;
    cyc(3);
    check("rst_vec", 64'(interrupt_vector), 64'd0);
    check("rst_rdata", bus_read_data, 64'd0);
    irq_src = 4'b0000;
    cyc(1);
    KEY0 = 1'b1;
    cyc(1);
    bus_address = A_PEND;
    #1 check("hit_base", 64'(bus_hit), 64'd1);
    bus_address = 64'h0000_0001_0000_FFE0;
    #1 check("hit_miss", 64'(bus_hit), 64'd0);
    cyc(1);
    bus_rd(A_PEND, rd); check("rst_pending", rd, 64'd0);
    bus_rd(A_EN, rd);   check("rst_enable", rd, 64'hF);
    bus_rd(A_RSV, rd);  check("rsv_read", rd, 64'd0);

    // Write and read of the same register in one cycle returns the old value
    bus_address      = A_EN;
    bus_write_data   = 64'h5;
    bus_write_enable = 1'b1;
    bus_read_enable  = 1'b1;
    cyc(1);
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
    check("wr_rd_same", bus_read_data, 64'hF);
    bus_rd(A_EN, rd); check("enable_new", rd, 64'h5);
    bus_wr(A_EN, 64'hF);

    // Priority and long ack
    irq_src = 4'b0110;
    cyc(1);
    irq_src = 4'b0000;
    check("prio_lat1", 64'(interrupt_vector), 64'd0);
    cyc(1);
    check("prio_vec2", 64'(interrupt_vector), 64'd2);
    interrupt_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      check("ack_hold", 64'(interrupt_vector), 64'd0);
    end
    interrupt_ack = 1'b0;
    cyc(1);
    check("ack_drop0", 64'(interrupt_vector), 64'd0);
    cyc(1);
    check("next_vec3", 64'(interrupt_vector), 64'd3);
    ack_pulse();
    check("ack2_vec", 64'(interrupt_vector), 64'd0);
    bus_rd(A_PEND, rd); check("ack2_pending", rd, 64'd0);

    // Masking: pending is recorded even though arbitration ignores it
    bus_wr(A_EN, 64'hE);
    irq_src = 4'b0001;
    cyc(1);
    irq_src = 4'b0000;
    cyc(3);
    check("mask_vec", 64'(interrupt_vector), 64'd0);
    bus_rd(A_PEND, rd); check("mask_pending", rd, 64'h1);
    bus_wr(A_EN, 64'hF);
    check("unmask_lat", 64'(interrupt_vector), 64'd0);
    cyc(1);
    check("unmask_vec", 64'(interrupt_vector), 64'd1);
    ack_pulse();
    cyc(2);

    // Level source held high re-requests after the ack drops
    irq_src = 4'b0001;
    cyc(2);
    check("lvl_vec1", 64'(interrupt_vector), 64'd1);
    ack_pulse();
    check("lvl_ack", 64'(interrupt_vector), 64'd0);
    cyc(1);
    check("lvl_idle", 64'(interrupt_vector), 64'd0);
    cyc(1);
    check("lvl_again", 64'(interrupt_vector), 64'd1);
    irq_src = 4'b0000;
    ack_pulse();
    cyc(3);
    check("lvl_clean", 64'(interrupt_vector), 64'd0);
    bus_rd(A_PEND, rd); check("lvl_pending", rd, 64'd0);

    // Edge source held high does not re-request
    irq_src = 4'b1000;
    cyc(2);
    check("edge_vec4", 64'(interrupt_vector), 64'd4);
    ack_pulse();
    cyc(5);
    check("edge_norearm", 64'(interrupt_vector), 64'd0);
    bus_rd(A_PEND, rd); check("edge_pending", rd, 64'd0);
    irq_src = 4'b0000;
    cyc(1);
    irq_src = 4'b1000;
    cyc(2);
    check("edge_rearm", 64'(interrupt_vector), 64'd4);
    irq_src = 4'b0000;
    ack_pulse();
    cyc(2);

    // Set wins over W1C on the same bit, then withdrawal via W1C
    irq_src = 4'b0010;
    bus_wr(A_PEND, 64'h2);
    irq_src = 4'b0000;
    cyc(1);
    check("collide_vec", 64'(interrupt_vector), 64'd2);
    bus_rd(A_PEND, rd); check("collide_pending", rd, 64'h2);
    bus_rd(A_ACT, rd);  check("active_read", rd, 64'h2);
    bus_wr(A_PEND, 64'h2);
    check("withdraw_vec", 64'(interrupt_vector), 64'd0);
    cyc(2);
    check("withdraw_stay", 64'(interrupt_vector), 64'd0);
    bus_rd(A_PEND, rd); check("withdraw_pending", rd, 64'd0);

    // Asynchronous reset while in ACKWAIT with a request still pending
    bus_wr(A_EN, 64'hF);
    irq_src = 4'b0110;
    cyc(1);
    irq_src = 4'b0000;
    cyc(1);
    check("pre_rst_vec", 64'(interrupt_vector), 64'd2);
    interrupt_ack = 1'b1;
    cyc(1);
    bus_rd(A_EN, rd); check("pre_rst_rdata", rd, 64'hF);
    #3 KEY0 = 1'b0;
    #1 check("aw_rst_vec", 64'(interrupt_vector), 64'd0);
    check("aw_rst_rdata", bus_read_data, 64'd0);
    cyc(2);
    KEY0 = 1'b1;
    cyc(3);
    check("post_rst_vec", 64'(interrupt_vector), 64'd0);
    bus_rd(A_PEND, rd); check("post_rst_pending", rd, 64'd0);
    bus_rd(A_EN, rd);   check("post_rst_enable", rd, 64'hF);
    interrupt_ack = 1'b0;
    cyc(2);
    check("post_rst_idle", 64'(interrupt_vector), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
